// File: rtl/param_stack.sv
// LIFO stack with registered pop data, combinational top peek and sticky error flags.
// Define PARAM_STACK_EDGE_EN to act on rising edges of push/pop instead of level strobes.
module param_stack #(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 50,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_val,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_val,
  output logic             pop_valid,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ev;
  logic             pop_ev;
  logic             push_act;
  logic             pop_act;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    top_idx;

`ifdef PARAM_STACK_EDGE_EN
  logic push_q;
  logic pop_q;

  // History resets high so an input held through reset release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_q <= 1'b1;
      pop_q  <= 1'b1;
    end else begin
      push_q <= push;
      pop_q  <= pop;
    end
  end

  assign push_ev = push & ~push_q;
  assign pop_ev  = pop & ~pop_q;
`else
  assign push_ev = push;
  assign pop_ev  = pop;
`endif

  assign push_act = en & ~clr & push_ev;
  assign pop_act  = en & ~clr & pop_ev;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign top_idx = AW'(count - CNT_W'(1));
  assign top     = empty ? '0 : mem[top_idx];

  // A simultaneous push and pop on a non-empty stack overwrites the top in place.
  assign wr_en   = push_act & (pop_act | ~full);
  assign wr_addr = (pop_act & ~empty) ? top_idx : count[AW-1:0];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= push_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      pop_val   <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      count     <= '0;
      pop_val   <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_val   <= '0;
      pop_valid <= 1'b0;
      if (pop_act) begin
        if (!empty) begin
          pop_val   <= mem[top_idx];
          pop_valid <= 1'b1;
          if (!push_act) begin
            count <= count - CNT_W'(1);
          end
        end else begin
          underflow <= 1'b1;
          if (push_act) begin
            count <= CNT_W'(1);
          end
        end
      end else if (push_act) begin
        if (full) begin
          overflow <= 1'b1;
        end else begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// Directed bench for param_stack at WIDTH=2, DEPTH=4; covers both edge and level builds.
module tb_param_stack;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             en;
  logic             clr;
  logic             push;
  logic [WIDTH-1:0] push_val;
  logic             pop;
  logic [WIDTH-1:0] pop_val;
  logic             pop_valid;
  logic [WIDTH-1:0] top;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;

  int checks;
  int fails;

  param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .push(push), .push_val(push_val), .pop(pop),
    .pop_val(pop_val), .pop_valid(pop_valid), .top(top), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idleCycle();
    push = 1'b0;
    pop  = 1'b0;
    clr  = 1'b0;
    en   = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Idle edge first so edge-mode history sees a low before each request.
  task automatic applyStimulus(input logic p, input logic [WIDTH-1:0] v,
                               input logic q, input logic e, input logic c);
    idleCycle();
    push     = p;
    push_val = v;
    pop      = q;
    en       = e;
    clr      = c;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    clr  = 1'b0;
    en   = 1'b1;
  endtask

  initial begin
    checks   = 0;
    fails    = 0;
    rst      = 1'b0;
    en       = 1'b1;
    clr      = 1'b0;
    push     = 1'b0;
    push_val = '0;
    pop      = 1'b0;
    #2;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_top", top, 0);
    checkOutput("rst_pop_valid", pop_valid, 0);
    checkOutput("rst_flags", {overflow, underflow}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // push 1,2,3 then pop three times
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
    checkOutput("push1_top", top, 1);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("push3_count", count, 3);
    checkOutput("push3_top", top, 3);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("pop1_val", pop_val, 3);
    checkOutput("pop1_valid", pop_valid, 1);
    checkOutput("pop1_count", count, 2);
    idleCycle();
    checkOutput("pulse_end_valid", pop_valid, 0);
    checkOutput("pulse_end_val", pop_val, 0);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("pop2_val", pop_val, 2);
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("pop3_val", pop_val, 1);
    checkOutput("pop3_valid", pop_valid, 1);
    checkOutput("pop3_count", count, 0);
    checkOutput("pop3_empty", empty, 1);
    checkOutput("pop3_top", top, 0);

    // fill to full then overflow
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
    checkOutput("fill_count", count, 4);
    checkOutput("fill_full", full, 1);
    checkOutput("fill_ovf", overflow, 0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_count", count, 4);
    checkOutput("ovf_top", top, 1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_ovf", overflow, 0);
    checkOutput("clr_count", count, 0);

    // underflow
    applyStimulus(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    checkOutput("udf_flag", underflow, 1);
    checkOutput("udf_valid", pop_valid, 0);
    checkOutput("udf_val", pop_val, 0);
    idleCycle();
    checkOutput("udf_sticky", underflow, 1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_udf", underflow, 0);

    // replace-top
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b1, 1'b0);
    checkOutput("rep_val", pop_val, 2);
    checkOutput("rep_valid", pop_valid, 1);
    checkOutput("rep_top", top, 3);
    checkOutput("rep_count", count, 2);

    // en low ignores requests
    applyStimulus(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    checkOutput("en_low_count", count, 2);
    checkOutput("en_low_valid", pop_valid, 0);
    checkOutput("en_low_top", top, 3);

    // push and pop together while empty
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 2'd2, 1'b1, 1'b1, 1'b0);
    checkOutput("both_empty_count", count, 1);
    checkOutput("both_empty_udf", underflow, 1);
    checkOutput("both_empty_valid", pop_valid, 0);
    checkOutput("both_empty_top", top, 2);

    // push held high for five cycles
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    idleCycle();
    push     = 1'b1;
    push_val = 2'd1;
    repeat (5) @(posedge clk);
    #1;
    push = 1'b0;
`ifdef PARAM_STACK_EDGE_EN
    checkOutput("held_count", count, 1);
    checkOutput("held_ovf", overflow, 0);
`else
    checkOutput("held_count", count, 4);
    checkOutput("held_ovf", overflow, 1);
`endif

    // asynchronous reset mid-push
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("pre_rst_count", count, 3);
    idleCycle();
    push     = 1'b1;
    push_val = 2'd2;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_count", count, 0);
    checkOutput("arst_top", top, 0);
    checkOutput("arst_empty", empty, 1);
    checkOutput("arst_flags", {overflow, underflow, pop_valid}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push = 1'b0;
`ifdef PARAM_STACK_EDGE_EN
    checkOutput("release_count", count, 0);
`else
    checkOutput("release_count", count, 1);
    checkOutput("release_top", top, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
